dbus_arbiter: RTL and testbench

Two-master arbiter for the shared data bus (data RAM plus memory-mapped GPIO) of the RV32I core. Master 0 is the core datapath data port; master 1 is a secondary bus master (program loader / debug / DMA). The block grants at most one access per cycle, drives the shared bus from the winner, and returns synchronous-RAM read data to the issuing master after a fixed latency. It also generates a stall toward the pipeline controller while master 0 is waiting.

---
 rtl/dbus_arbiter.sv | 129 ++++++++++++
 tb/tb_dbus_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dbus_arbiter.sv
// Two-master shared data-bus arbiter: master 0 has priority, limited by a run counter
// so master 1 cannot starve. Read data comes back through a fixed-latency owner tracker.

module dbus_rport #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          inrst,
  input  logic          hit,
  input  logic [DW-1:0] s_rdata,
  output logic          rvalid,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] hold;

  // Non-owner returns leave this master's data bus untouched.
  always_ff @(posedge clk or negedge inrst) begin
    if (!inrst)   hold <= '0;
    else if (hit) hold <= s_rdata;
  end

  assign rvalid = hit;
  assign rdata  = hit ? s_rdata : hold;
endmodule

module dbus_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int RD_LAT  = 1,
  parameter int MAX_RUN = 4
) (
  input  logic          clk,
  input  logic          inrst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_stall,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  output logic          s_we,
  input  logic [DW-1:0] s_rdata
);
  localparam int          STAGES  = RD_LAT;
  localparam logic [3:0]  RUN_MAX = 4'(MAX_RUN);

  logic [1:0]          gnt, hit, rvalid;
  logic [1:0][DW-1:0]  rdata;
  logic [3:0]          run_cnt;
  logic [STAGES-1:0]   vld_pipe, own_pipe;
  logic [AW-1:0]       addr_q, w_addr;
  logic [DW-1:0]       wdata_q, w_wdata;
  logic                w_we, any_gnt, vld_in;

  always_comb begin
    gnt = '0;
    if (inrst) begin
      if (m1_req && (!m0_req || run_cnt == RUN_MAX)) gnt[1] = 1'b1;
      else if (m0_req)                               gnt[0] = 1'b1;
    end
  end

  assign any_gnt  = |gnt;
  assign w_addr   = gnt[1] ? m1_addr  : m0_addr;
  assign w_wdata  = gnt[1] ? m1_wdata : m0_wdata;
  assign w_we     = gnt[1] ? m1_we    : m0_we;
  assign vld_in   = any_gnt & ~w_we;

  assign m0_gnt   = gnt[0];
  assign m1_gnt   = gnt[1];
  assign m0_stall = m0_req & ~gnt[0];

  // Idle bus keeps the last granted address/data so the RAM pins do not toggle.
  assign s_addr   = any_gnt ? w_addr  : addr_q;
  assign s_wdata  = any_gnt ? w_wdata : wdata_q;
  assign s_we     = any_gnt & w_we;

  always_ff @(posedge clk or negedge inrst) begin
    if (!inrst) begin
      run_cnt  <= '0;
      vld_pipe <= '0;
      own_pipe <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      if (!m1_req || gnt[1])                run_cnt <= '0;
      else if (gnt[0] && run_cnt != RUN_MAX) run_cnt <= run_cnt + 4'd1;
      vld_pipe[0] <= vld_in;
      own_pipe[0] <= gnt[1];
      for (int i = 1; i < STAGES; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        own_pipe[i] <= own_pipe[i-1];
      end
      if (any_gnt) begin
        addr_q  <= w_addr;
        wdata_q <= w_wdata;
      end
    end
  end

  assign hit[0] = vld_pipe[STAGES-1] & ~own_pipe[STAGES-1];
  assign hit[1] = vld_pipe[STAGES-1] &  own_pipe[STAGES-1];

  for (genvar m = 0; m < 2; m++) begin : g_rport
    dbus_rport #(.DW(DW)) u_rport (
      .clk    (clk),
      .inrst  (inrst),
      .hit    (hit[m]),
      .s_rdata(s_rdata),
      .rvalid (rvalid[m]),
      .rdata  (rdata[m])
    );
  end

  assign m0_rvalid = rvalid[0];
  assign m0_rdata  = rdata[0];
  assign m1_rvalid = rvalid[1];
  assign m1_rdata  = rdata[1];
endmodule

// File: tb/tb_dbus_arbiter.sv
// Randomized bench for dbus_arbiter: a transaction-level model predicts grants,
// bus drive and read returns from the arbitration rules and a model memory.
module tb_dbus_arbiter;
  localparam int AW = 32, DW = 32, RD_LAT = 2, MAX_RUN = 4;

  logic clk = 1'b0, inrst = 1'b0;
  logic m0_req, m0_we, m0_gnt, m0_stall, m0_rvalid;
  logic m1_req, m1_we, m1_gnt, m1_rvalid;
  logic [AW-1:0] m0_addr, m1_addr, s_addr;
  logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, s_wdata, s_rdata;
  logic s_we;

  always #5 clk = ~clk;

  dbus_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_RUN(MAX_RUN)) dut (
    .clk(clk), .inrst(inrst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_stall(m0_stall), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_we(s_we), .s_rdata(s_rdata)
  );

  function automatic logic [DW-1:0] init_word(int i);
    return (i == 4) ? 32'hDEADBEEF : ((32'(i) * 32'h01010101) ^ 32'h5A5A0000);
  endfunction

  // Synchronous RAM on the shared bus, contents reloaded while in reset.
  logic [DW-1:0] mem [16];
  logic [DW-1:0] dq  [RD_LAT];
  always @(posedge clk) begin
    if (!inrst) for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
    else if (s_we) mem[s_addr[5:2]] <= s_wdata;
    dq[0] <= mem[s_addr[5:2]];
    for (int i = 1; i < RD_LAT; i++) dq[i] <= dq[i-1];
  end
  assign s_rdata = dq[RD_LAT-1];

  typedef struct { int due; bit own; logic [DW-1:0] data; } ret_t;
  ret_t          rq[$];
  logic [DW-1:0] mmem [16];
  logic [DW-1:0] last_rd [2];
  logic [AW-1:0] held_a;
  logic [DW-1:0] held_d;
  int            m0_wins;   // m0 grants since m1 began its current wait
  int            cyc = 0;
  int            total = 0, bad = 0;

  bit            p_req [2];
  bit            p_we  [2];
  logic [AW-1:0] p_addr[2];
  logic [DW-1:0] p_wd  [2];
  bit            force_req = 0;
  int            rate = 0;
  bit            rst_drv = 0;
  bit            e0, e1, smp_we, smp_rv0, smp_rv1;
  logic [DW-1:0] smp_wd, smp_rd0, smp_rd1;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    rq.delete();
    for (int i = 0; i < 16; i++) mmem[i] = init_word(i);
    last_rd[0] = '0; last_rd[1] = '0;
    held_a = '0; held_d = '0; m0_wins = 0;
  endtask

  task automatic new_req(int m, bit we, logic [AW-1:0] a, logic [DW-1:0] d);
    p_req[m] = 1; p_we[m] = we; p_addr[m] = a; p_wd[m] = d;
  endtask

  task automatic step();
    bit rv0, rv1;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    @(negedge clk);
    for (int m = 0; m < 2; m++)
      if (!p_req[m] && (force_req || $urandom_range(0, 99) < rate))
        new_req(m, force_req ? 1'b0 : ($urandom_range(0, 9) < 3),
                ($urandom & 32'hFFFF_FFC3) | (32'($urandom_range(0, 15)) << 2), $urandom);
    inrst = rst_drv;
    m0_req = p_req[0]; m0_we = p_we[0]; m0_addr = p_addr[0]; m0_wdata = p_wd[0];
    m1_req = p_req[1]; m1_we = p_we[1]; m1_addr = p_addr[1]; m1_wdata = p_wd[1];
    #1;
    if (!inrst) model_reset();
    e1 = inrst && p_req[1] && (!p_req[0] || m0_wins >= MAX_RUN);
    e0 = inrst && p_req[0] && !e1;
    rv0 = rq.size() > 0 && rq[0].due == cyc && rq[0].own == 0;
    rv1 = rq.size() > 0 && rq[0].due == cyc && rq[0].own == 1;
    ea = e1 ? p_addr[1] : e0 ? p_addr[0] : held_a;
    ed = e1 ? p_wd[1]   : e0 ? p_wd[0]   : held_d;
    chk("m0_gnt", m0_gnt, e0);
    chk("m1_gnt", m1_gnt, e1);
    chk("m0_stall", m0_stall, p_req[0] && !e0);
    chk("s_we", s_we, (e0 && p_we[0]) || (e1 && p_we[1]));
    chk("s_addr", s_addr, ea);
    chk("s_wdata", s_wdata, ed);
    chk("m0_rvalid", m0_rvalid, rv0);
    chk("m1_rvalid", m1_rvalid, rv1);
    chk("m0_rdata", m0_rdata, rv0 ? rq[0].data : last_rd[0]);
    chk("m1_rdata", m1_rdata, rv1 ? rq[0].data : last_rd[1]);
    smp_we = s_we; smp_wd = s_wdata;
    smp_rv0 = m0_rvalid; smp_rv1 = m1_rvalid; smp_rd0 = m0_rdata; smp_rd1 = m1_rdata;
    @(posedge clk);
    if (inrst) begin
      if (rv0 || rv1) begin last_rd[rv1] = rq[0].data; void'(rq.pop_front()); end
      if (e0 || e1) begin
        int w = e1 ? 1 : 0;
        if (p_we[w]) mmem[p_addr[w][5:2]] = p_wd[w];
        else rq.push_back('{cyc + RD_LAT, bit'(w), mmem[p_addr[w][5:2]]});
        held_a = p_addr[w]; held_d = p_wd[w];
        p_req[w] = 0;
      end
      if (!p_req[1] && !e1) m0_wins = 0;
      else if (e1) m0_wins = 0;
      else if (e0) m0_wins++;
    end
    cyc++;
  endtask

  task automatic idle(int n);
    rate = 0; force_req = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    logic [11:0] g1_seq;
    logic [2:0]  rv_seq0, rv_seq1;
    int          rv_cnt;
    model_reset();
    p_req[0] = 0; p_req[1] = 0;
    // Reset with both requests held, then release straight into contention.
    new_req(0, 0, 32'h10, '0);
    new_req(1, 0, 32'h14, '0);
    rst_drv = 0;
    for (int i = 0; i < 3; i++) step();
    rst_drv = 1; force_req = 1;
    g1_seq = '0;
    for (int i = 0; i < 12; i++) begin
      step();
      g1_seq[i] = m1_gnt;
      if (i == 0) chk("release_m0_gnt", e0, 1'b1);
    end
    chk("contention_seq", g1_seq, 12'b0010_0001_0000);
    p_req[0] = 0; p_req[1] = 0;
    idle(RD_LAT + 2);

    // Uncontended read of 0x10.
    new_req(0, 0, 32'h10, '0);
    step();
    chk("unc_gnt", m0_gnt, 1'b1);
    for (int i = 0; i < RD_LAT; i++) step();
    chk("unc_rvalid", smp_rv0, 1'b1);
    chk("unc_rdata", smp_rd0, 32'hDEADBEEF);
    chk("unc_m1_rvalid", smp_rv1, 1'b0);
    idle(2);

    // Interleaved back-to-back reads from both masters.
    new_req(0, 0, 32'h0, '0); step();
    new_req(1, 0, 32'h4, '0); step();
    new_req(0, 0, 32'h8, '0);
    rv_seq0 = '0; rv_seq1 = '0;
    for (int i = 0; i < RD_LAT + 3; i++) begin
      step();
      if (i >= RD_LAT - 2 && i < RD_LAT + 1) begin
        rv_seq0[i - (RD_LAT - 2)] = smp_rv0;
        rv_seq1[i - (RD_LAT - 2)] = smp_rv1;
      end
    end
    chk("ilv_m0_pulses", rv_seq0, 3'b101);
    chk("ilv_m1_pulses", rv_seq1, 3'b010);
    idle(2);

    // GPIO write from master 1.
    new_req(1, 1, 32'h3C, 32'h55);
    step();
    chk("wr_s_we", smp_we, 1'b1);
    chk("wr_s_wdata", smp_wd, 32'h55);
    step();
    chk("wr_s_we_off", smp_we, 1'b0);
    chk("wr_no_rvalid", smp_rv0 | smp_rv1, 1'b0);
    idle(RD_LAT);

    rate = 45;
    for (int i = 0; i < 2000; i++) step();
    p_req[0] = 0; p_req[1] = 0;
    idle(RD_LAT + 2);

    // Reset one cycle after a read grant: the return must vanish.
    new_req(0, 0, 32'h20, '0);
    step();
    rst_drv = 0;
    rv_cnt = 0;
    for (int i = 0; i < 3; i++) begin step(); rv_cnt += int'(smp_rv0); end
    rst_drv = 1;
    for (int i = 0; i < RD_LAT + 3; i++) begin step(); rv_cnt += int'(smp_rv0); end
    chk("rst_mid_read", 64'(rv_cnt), 64'd0);

    rate = 60;
    for (int i = 0; i < 1000; i++) step();
    p_req[0] = 0; p_req[1] = 0;
    idle(RD_LAT + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
